// File: rtl/core_exec_controller.sv
// core_exec_controller: boot reset, core reset pulse, core clock enable (run/stop/step) and core cycle counting.
module core_exec_controller #(
  parameter int BOOT_CYCLES        = 20,
  parameter int RESET_CLK_CYCLES   = 20,
  parameter int PULSE_CONTROL_BITS = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [3:0]                    cmd_op,
  input  logic [PULSE_CONTROL_BITS-1:0] cmd_arg,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_data,
  output logic                          core_clk_en,
  output logic                          reset_core,
  output logic                          boot_done
);
  localparam int TMAX = (BOOT_CYCLES > RESET_CLK_CYCLES) ? BOOT_CYCLES : RESET_CLK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = PULSE_CONTROL_BITS;

  typedef enum logic [2:0] {BOOT, IDLE, RUN, STEP, RESETTING} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   step_q, step_d, cyc_q, cyc_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic            core_clk_en_q, core_clk_en_d, reset_core_q, reset_core_d;
  logic            boot_done_q, boot_done_d, acc;
  logic [PW+31:0]  cyc_ext;

  always_comb begin
    acc         = cmd_valid & cmd_ready_q;
    cyc_ext     = {32'b0, cyc_q};
    state_d     = state_q;
    timer_d     = timer_q;
    step_d      = step_q;
    cyc_d       = (core_clk_en_q & ~reset_core_q) ? cyc_q + 1'b1 : cyc_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      BOOT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(BOOT_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      RESETTING: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == TW'(RESET_CLK_CYCLES - 1)) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      STEP: begin
        step_d = step_q - 1'b1;
        if (step_q == PW'(1)) state_d = IDLE;
      end
      default: ;
    endcase
    // Commands are only accepted in IDLE/RUN, so they never collide with the timers above.
    if (acc) begin
      case (cmd_op)
        4'd1: begin
          state_d = RESETTING;
          timer_d = '0;
          cyc_d   = '0;
        end
        4'd2: state_d = RUN;
        4'd3: state_d = IDLE;
        4'd4: begin
          state_d = (cmd_arg == '0) ? IDLE : STEP;
          step_d  = cmd_arg;
        end
        4'd5: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cyc_ext[31:0];
        end
        4'd6: begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = {28'b0, state_q == RESETTING, state_q == STEP, state_q == RUN, boot_done_q};
        end
        default: ;
      endcase
    end
    cmd_ready_d   = (state_d == IDLE) || (state_d == RUN);
    core_clk_en_d = (state_d == RUN) || (state_d == STEP) || (state_d == RESETTING);
    reset_core_d  = (state_d == BOOT) || (state_d == RESETTING);
    boot_done_d   = boot_done_q | (state_d != BOOT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      timer_q       <= '0;
      step_q        <= '0;
      cyc_q         <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      cmd_ready_q   <= 1'b0;
      core_clk_en_q <= 1'b0;
      reset_core_q  <= 1'b1;
      boot_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      step_q        <= step_d;
      cyc_q         <= cyc_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      core_clk_en_q <= core_clk_en_d;
      reset_core_q  <= reset_core_d;
      boot_done_q   <= boot_done_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign core_clk_en = core_clk_en_q;
  assign reset_core  = reset_core_q;
  assign boot_done   = boot_done_q;
endmodule

// File: tb/tb_core_exec_controller.sv
// tb_core_exec_controller: scoreboarded responses plus directed timing checks of boot, step, run, reset and async abort.
module tb_core_exec_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_arg = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        core_clk_en, reset_core, boot_done;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_q[$];

  core_exec_controller dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .core_clk_en(core_clk_en), .reset_core(reset_core), .boot_done(boot_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300 && !cmd_ready; i++) cyc();
    chk("ready_wait", cmd_ready, 1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] arg);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic read(input logic [3:0] op, input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(op, 32'd0);
    cyc();
  endtask

  task automatic boot();
    int k = 0;
    rst_n = 1'b1;
    while (reset_core && k < 40) begin
      cyc();
      k++;
    end
    chk("boot_len", k, 20);
    chk("boot_done", boot_done, 1);
    chk("boot_ready", cmd_ready, 1);
    chk("boot_en", core_clk_en, 0);
    repeat (5) cyc();
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      chk("rsp_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("rsp_data", rsp_data, exp_q.pop_front());
    end
  end

  initial begin
    int en_n, ovl_n, rst_len;
    #18;
    chk("rst_reset_core", reset_core, 1);
    chk("rst_en", core_clk_en, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_data[30:0]}, 0);
    chk("rst_boot_done", boot_done, 0);
    #5;
    boot();
    issue(4'd4, 32'd0);
    en_n = 0;
    repeat (6) begin
      en_n += int'(core_clk_en);
      cyc();
    end
    chk("step0_en", en_n, 0);
    read(4'd5, 32'd0);
    issue(4'd4, 32'd5);
    en_n = 0;
    ovl_n = 0;
    repeat (8) begin
      en_n  += int'(core_clk_en);
      ovl_n += int'(core_clk_en & cmd_ready);
      cyc();
    end
    chk("step5_en", en_n, 5);
    chk("step5_ready_low", ovl_n, 0);
    read(4'd5, 32'd5);
    issue(4'd2, 32'd0);
    repeat (4) cyc();
    read(4'd6, 32'h3);
    repeat (3) cyc();
    issue(4'd3, 32'd0);
    chk("stop_en", core_clk_en, 0);
    read(4'd5, 32'd15);
    issue(4'd4, 32'd7);
    issue(4'd1, 32'd0);
    rst_len = 0;
    repeat (25) begin
      rst_len += int'(reset_core & core_clk_en);
      cyc();
    end
    chk("rcore_len", rst_len, 20);
    chk("rcore_idle_ready", cmd_ready, 1);
    chk("rcore_idle_rst", reset_core, 0);
    read(4'd5, 32'd0);
    issue(4'd2, 32'd0);
    issue(4'd2, 32'd0);
    issue(4'd4, 32'd3);
    wait_ready();
    read(4'd5, 32'd5);
    issue(4'd9, 32'd0);
    read(4'd6, 32'h1);
    issue(4'd4, 32'd100);
    repeat (30) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_reset_core", reset_core, 1);
    chk("abort_en", core_clk_en, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_boot_done", boot_done, 0);
    chk("abort_rsp_data", rsp_data, 0);
    #7;
    boot();
    read(4'd5, 32'd0);
    chk("rsp_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/core_exec_controller.md
Name: core_exec_controller

Overview:
- Execution-control block between a host command source and a processor core under test.
- Generates the power-up boot reset, the core reset pulse and the core clock enable (free-run, stop, N-cycle step).
- Counts executed core cycles for readback.
- Replaces the clock/reset portion of the processor-CI controller; the host-side transport (UART/SPI) and memory bus sit outside this block.

Parameters:
- BOOT_CYCLES, 20: cycles the block stays in boot after rst_n release.
- RESET_CLK_CYCLES, 20: length of a commanded core reset pulse, in cycles.
- PULSE_CONTROL_BITS, 32: width of the STEP argument and of the core cycle counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  4  opcode.
- cmd_arg  in  PULSE_CONTROL_BITS  command argument.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_data  out  32  response word.
- core_clk_en  out  1  core clock enable (core clock = clk gated by this, externally).
- reset_core  out  1  active-high core reset.
- boot_done  out  1  high once boot sequence finished.

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values while rst_n=0:
  - state=BOOT; reset_core=1, core_clk_en=0.
  - cmd_ready=0, rsp_valid=0, rsp_data=0, boot_done=0.
  - cycle counter=0, internal timer=0.
- States and transitions:
  - BOOT: reset_core=1, core_clk_en=0. Timer counts clk edges after rst_n release. After exactly BOOT_CYCLES edges: go to IDLE, boot_done=1 (stays 1 until rst_n), reset_core=0.
  - IDLE: core_clk_en=0, cmd_ready=1.
  - RUN: core_clk_en=1, cmd_ready=1.
  - STEP: core_clk_en=1, cmd_ready=0. Down-counter loaded with cmd_arg. Returns to IDLE after exactly N enabled cycles.
  - RESETTING: reset_core=1 and core_clk_en=1 (core must see clock edges during reset), cmd_ready=0. Exactly RESET_CLK_CYCLES cycles, then IDLE.
- Handshake: a command is accepted on an edge where cmd_valid=1 and cmd_ready=1. cmd_ready is registered and is a function of state only.
- Opcodes (state effects start the cycle after acceptance):
  - 0 NOP: no effect.
  - 1 RESET_CORE: enter RESETTING; clear cycle counter.
  - 2 RUN: enter RUN.
  - 3 STOP: enter IDLE.
  - 4 STEP: if cmd_arg=0 stay in IDLE with no enable pulse; otherwise enter STEP with N=cmd_arg.
  - 5 READ_CYCLES: rsp_data = low 32 bits of the cycle counter at acceptance.
  - 6 READ_STATUS: rsp_data = {28'b0, resetting, stepping, running, boot_done}.
  - 7–15: treated as NOP.
- Response timing: rsp_valid=1 for exactly one cycle, the cycle after a read is accepted. rsp_data holds its value until the next read.
- Cycle counter:
  - Increments on every edge with core_clk_en=1 and reset_core=0.
  - Wraps at 2^PULSE_CONTROL_BITS.
  - Not counted during RESETTING.
- STEP/RUN issued while already in RUN: STEP stops free-run and runs N more cycles; RUN is a no-op.
- rst_n assertion at any time aborts every state immediately (asynchronous) and returns to BOOT values. A full boot runs again after release.
- All outputs are registered; no combinational path from cmd_* to any output.

Test Plan:
- Boot: release rst_n, idle 25 cycles -> reset_core=1 for exactly 20 edges, then reset_core=0, boot_done=1, cmd_ready=1, core_clk_en=0.
- STEP 5: after boot, issue op4 arg=5 -> core_clk_en high exactly 5 cycles, cmd_ready low in those cycles. Then READ_CYCLES -> rsp_valid pulse, rsp_data=5.
- STEP 0: op4 arg=0 -> core_clk_en never asserts; READ_CYCLES returns 0.
- RUN/STOP: RUN, wait 10 cycles, STOP -> count equals the number of enabled edges (10 or 11 per accept timing, exact). READ_STATUS while running returns 0x3.
- RESET_CORE: after STEP 7, op1 -> reset_core and core_clk_en both high exactly 20 cycles, then IDLE. READ_CYCLES returns 0.
- Async reset mid-STEP: STEP 100, pull rst_n low at cycle 30 -> outputs take reset values immediately; after release the 20-cycle boot repeats and the counter reads 0.
